button_event: RTL and testbench

- Per-button event decoder that sits directly downstream of the debounce stage on the board-level test harness.
- Consumes N debounced, clk_i-synchronous button levels and converts each into single-cycle event pulses: press, release, short click, long press and auto-repeat.
- Feeds the cache-test control logic, which steps test phases and selects display pages from these pulses.

---
 rtl/button_event_if.sv | 23 ++
 rtl/button_event.sv | 126 ++++++++++++
 tb/tb_button_event.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/button_event_if.sv
// Button-level input and per-channel event pulses between the debounce stage and test control.
// Master drives btn_i; the decoder (slave) drives every event output.
interface button_event_if #(
    parameter int N = 4
);
    logic [N-1:0] btn_i;
    logic [N-1:0] press_o;
    logic [N-1:0] release_o;
    logic [N-1:0] short_o;
    logic [N-1:0] long_o;
    logic [N-1:0] repeat_o;
    logic [N-1:0] held_o;

    modport master (
        output btn_i,
        input  press_o, release_o, short_o, long_o, repeat_o, held_o
    );

    modport slave (
        input  btn_i,
        output press_o, release_o, short_o, long_o, repeat_o, held_o
    );
endinterface

// File: rtl/button_event.sv
// Per-button event decoder: press/release/short/long/repeat pulses plus a held level, per channel.
// Latency: one cycle from sampling edge to registered output; no backpressure, pulses are fire-and-forget.
module button_event #(
    parameter int N             = 4,
    parameter int CNTW          = 25,
    parameter int LONG_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    button_event_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HELD = 2'b01,
        LONG = 2'b10
    } state_t;

    localparam logic [CNTW-1:0] LONG_TOP   = CNTW'(LONG_CYCLES - 1);
    localparam logic [CNTW-1:0] REPEAT_TOP = CNTW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
    localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic            btn;
        logic            prev_q;
        state_t          state_q, state_d;
        logic [CNTW-1:0] cnt_q, cnt_d;
        logic            press_d, rel_d, short_d, long_d, rep_d, held_d;
        logic            press_q, rel_q, short_q, long_q, rep_q, held_q;

        assign btn = bus.btn_i[i];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                prev_q  <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                short_q <= 1'b0;
                long_q  <= 1'b0;
                rep_q   <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                prev_q  <= btn;
                press_q <= press_d;
                rel_q   <= rel_d;
                short_q <= short_d;
                long_q  <= long_d;
                rep_q   <= rep_d;
                held_q  <= held_d;
            end
        end

        // Release is tested before either threshold so it wins on a coincident edge.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (btn && !prev_q) begin
                        state_d = HELD;
                        cnt_d   = CNT_ONE;
                    end
                end
                HELD: begin
                    if (!btn) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == LONG_TOP) begin
                        state_d = LONG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                LONG: begin
                    if (!btn) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (REPEAT_CYCLES == 0 || cnt_q == REPEAT_TOP) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_comb begin
            press_d = 1'b0;
            rel_d   = 1'b0;
            short_d = 1'b0;
            long_d  = 1'b0;
            rep_d   = 1'b0;
            held_d  = (state_d == HELD) || (state_d == LONG);
            case (state_q)
                IDLE: press_d = btn && !prev_q;
                HELD: begin
                    rel_d   = !btn;
                    short_d = !btn;
                    long_d  = btn && (cnt_q == LONG_TOP);
                end
                LONG: begin
                    rel_d = !btn;
                    rep_d = btn && (REPEAT_CYCLES != 0) && (cnt_q == REPEAT_TOP);
                end
                default: ;
            endcase
        end

        assign bus.press_o[i]   = press_q;
        assign bus.release_o[i] = rel_q;
        assign bus.short_o[i]   = short_q;
        assign bus.long_o[i]    = long_q;
        assign bus.repeat_o[i]  = rep_q;
        assign bus.held_o[i]    = held_q;
    end
endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: explicit vector table, hand sequences, and a hold-length reference model.
module tb_button_event;
    localparam int L  = 8;
    localparam int RA = 4;
    localparam int RB = 0;

    localparam logic [5:0] P  = 6'b100000;
    localparam logic [5:0] R  = 6'b010000;
    localparam logic [5:0] S  = 6'b001000;
    localparam logic [5:0] LG = 6'b000100;
    localparam logic [5:0] RP = 6'b000010;
    localparam logic [5:0] H  = 6'b000001;

    typedef struct {
        logic       b;
        logic [5:0] e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int h [2][4];

    button_event_if #(.N(4)) ifa ();
    button_event_if #(.N(4)) ifb ();

    assign ifa.btn_i = btn;
    assign ifb.btn_i = btn;

    button_event #(.N(4), .CNTW(8), .LONG_CYCLES(L), .REPEAT_CYCLES(RA)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(ifa)
    );
    button_event #(.N(4), .CNTW(8), .LONG_CYCLES(L), .REPEAT_CYCLES(RB)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(ifb)
    );

    always #5 clk = ~clk;

    logic [23:0] act_a, act_b;
    assign act_a = {ifa.press_o, ifa.release_o, ifa.short_o, ifa.long_o, ifa.repeat_o, ifa.held_o};
    assign act_b = {ifb.press_o, ifb.release_o, ifb.short_o, ifb.long_o, ifb.repeat_o, ifb.held_o};

    function automatic logic [5:0] chan(input logic [23:0] v, input int c);
        return {v[20+c], v[16+c], v[12+c], v[8+c], v[4+c], v[c]};
    endfunction

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act === exp) passes++;
        else begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reset_model();
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < 4; c++) h[m][c] = 0;
    endtask

    // h counts consecutive high samples since the press edge; 0 means idle.
    task automatic model_edge(input int m, input logic [3:0] b, input int rep, output logic [23:0] e);
        logic [3:0] pr, rl, sh, lg, rp, hd;
        pr = '0; rl = '0; sh = '0; lg = '0; rp = '0; hd = '0;
        for (int c = 0; c < 4; c++) begin
            if (b[c]) begin
                h[m][c]++;
                hd[c] = 1'b1;
                if (h[m][c] == 1) pr[c] = 1'b1;
                if (h[m][c] == L) lg[c] = 1'b1;
                if (rep != 0 && h[m][c] > L && (h[m][c] - L) % rep == 0) rp[c] = 1'b1;
            end else begin
                if (h[m][c] > 0) begin
                    rl[c] = 1'b1;
                    sh[c] = (h[m][c] < L);
                end
                h[m][c] = 0;
            end
        end
        e = {pr, rl, sh, lg, rp, hd};
    endtask

    // Entered at a negedge; applies b at the next posedge and leaves at the following negedge.
    task automatic step(input logic [3:0] b);
        logic [23:0] ea, eb;
        btn = b;
        @(posedge clk);
        #1;
        model_edge(0, b, RA, ea);
        model_edge(1, b, RB, eb);
        chk("model_a", act_a, ea);
        chk("model_b", act_b, eb);
        chk("inv_press_release", {20'b0, ifa.press_o & ifa.release_o}, 24'b0);
        chk("inv_long_repeat", {20'b0, ifa.long_o & ifa.repeat_o}, 24'b0);
        @(negedge clk);
    endtask

    vec_t tbl [$];

    task automatic add(input logic b, input logic [5:0] e);
        vec_t v;
        v.b = b;
        v.e = e;
        tbl.push_back(v);
    endtask

    initial begin
        int nlong, nrep, nshort;
        logic [3:0] cur;
        reset_model();

        // Short click, 7-sample and 8-sample boundaries, back-to-back 1-0-1.
        add(1, P|H); add(1, H); add(1, H); add(0, R|S); add(0, 0);
        add(1, P|H); for (int i = 0; i < 6; i++) add(1, H); add(0, R|S); add(0, 0);
        add(1, P|H); for (int i = 0; i < 6; i++) add(1, H); add(1, LG|H); add(0, R); add(0, 0);
        add(1, P|H); add(0, R|S); add(1, P|H); add(0, R|S); add(0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", act_a, 24'b0);
        chk("reset_b", act_b, 24'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step({3'b000, tbl[i].b});
            chk($sformatf("table_%0d", i), {18'b0, chan(act_a, 0)}, {18'b0, tbl[i].e});
        end

        // Long hold: press at 1, long at 8, repeats every 4 after that; no-repeat DUT longs once.
        nlong = 0; nrep = 0;
        for (int k = 1; k <= 30; k++) begin
            step(4'b0001);
            chk($sformatf("hold_a_%0d", k), {18'b0, chan(act_a, 0)},
                {18'b0, ((k == 1) ? P : 6'b0) | ((k == 8) ? LG : 6'b0) |
                        ((k > 8 && (k - 8) % 4 == 0) ? RP : 6'b0) | H});
            nlong += int'(ifb.long_o[0]);
            nrep  += int'(ifb.repeat_o[0]);
        end
        chk("norep_long_count", 24'(nlong), 24'd1);
        chk("norep_repeat_count", 24'(nrep), 24'd0);
        step(4'b0000);
        chk("hold_release_a", {18'b0, chan(act_a, 0)}, {18'b0, R});
        chk("hold_release_b", {18'b0, chan(act_b, 0)}, {18'b0, R});

        // Asynchronous reset in the middle of a hold, button kept high throughout.
        for (int k = 0; k < 10; k++) step(4'b0001);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_a", act_a, 24'b0);
        chk("rst_async_b", act_b, 24'b0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        for (int k = 1; k <= 9; k++) begin
            step(4'b0001);
            chk($sformatf("post_rst_%0d", k), {18'b0, chan(act_a, 0)},
                {18'b0, ((k == 1) ? P : 6'b0) | ((k == 8) ? LG : 6'b0) | H});
        end
        step(4'b0000);

        // Channel 0 click overlapping a channel 2 long hold while channel 3 toggles.
        nlong = 0; nshort = 0;
        for (int k = 0; k < 14; k++) begin
            step({k[0], (k < 13), 1'b0, (k >= 2 && k < 5)});
            nlong  += int'(ifa.long_o[2]);
            nshort += int'(ifa.short_o[0]);
        end
        chk("multi_ch2_long", 24'(nlong), 24'd1);
        chk("multi_ch0_short", 24'(nshort), 24'd1);
        step(4'b0000);

        cur = 4'b0;
        for (int k = 0; k < 2000; k++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
            step(cur);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
